wb_serial_master: RTL and testbench

// - Byte-stream to Wishbone master bridge; sits directly upstream of the block RAM slave (wb_memory) on the SOC bus.
// - Parses command frames from a byte source (UART RX), issues one 8/16/32-bit single Wishbone access, returns the result to a byte sink (UART TX).
// - Intended for loading and inspecting memory from a host without a CPU.

---
 rtl/wb_serial_master_pkg.sv | 31 +++
 rtl/wb_serial_master_shifter.sv | 43 ++++
 rtl/wb_serial_master.sv | 209 ++++++++++++++++++++
 tb/tb_wb_serial_master.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_serial_master_pkg.sv
// Shared definitions for the byte-stream to Wishbone bridge.
// Contents: FSM state encoding, transfer width codes, response byte codes,
// and a helper that maps a width code to its byte count.
package wb_serial_master_pkg;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] W8    = 2'b00;
    localparam logic [1:0] W16   = 2'b01;
    localparam logic [1:0] W32   = 2'b10;
    localparam logic [1:0] W_BAD = 2'b11;

    localparam logic [7:0] RESP_OK  = 8'hAA;
    localparam logic [7:0] RESP_ERR = 8'hEE;

    function automatic logic [2:0] width_bytes(input logic [1:0] w);
        case (w)
            W8:      width_bytes = 3'd1;
            W16:     width_bytes = 3'd2;
            default: width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/wb_serial_master_shifter.sv
// Response serialiser: loads up to four bytes in one cycle and presents them
// LSB first on a valid/ready byte interface.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                capture load_data/load_count (overrides shifting)
//   load_data[31:0]     bytes to send, byte 0 first
//   load_count[2:0]     number of bytes to send (1..4)
//   tx_valid/tx_data    byte output
//   tx_ready            sink accepts tx_data when tx_valid & tx_ready
//   last                the byte currently presented is the final one
module wb_serial_master_shifter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic [2:0]  load_count,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        last
);

    logic [31:0] data;
    logic [2:0]  count;

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= load_count;
        end else if (tx_valid && tx_ready) begin
            data  <= {8'h00, data[31:8]};
            count <= count - 3'd1;
        end
    end

    assign tx_valid = (count != 3'd0);
    assign tx_data  = data[7:0];
    assign last     = (count == 3'd1);

endmodule

// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone master bridge. Parses {cmd, addr bytes, data bytes}
// frames from a byte source, performs one 8/16/32-bit single access and sends
// the result (0xAA for writes, read data LSB first, 0xEE on error) to a byte sink.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   i_rx_valid/i_rx_data/o_rx_ready   command byte input
//   o_tx_valid/o_tx_data/i_tx_ready   response byte output
//   o_wb_cyc/o_wb_stb/i_wb_stl/i_wb_ack  Wishbone handshake
//   o_we/o_width/o_addr/o_data/i_data    Wishbone access attributes and data
//   o_busy                            high whenever not waiting for a command
// Build option: define WB_MASTER_TIMEOUT_EN to abort an access that has not been
// acknowledged within TIMEOUT_CYCLES cycles and answer 0xEE.
module wb_serial_master
    import wb_serial_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_data,
    output logic                  o_rx_ready,
    output logic                  o_tx_valid,
    output logic [7:0]            o_tx_data,
    input  logic                  i_tx_ready,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    input  logic                  i_wb_stl,
    input  logic                  i_wb_ack,
    output logic                  o_we,
    output logic [1:0]            o_width,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_data,
    input  logic [31:0]           i_data,
    output logic                  o_busy
);

    localparam int         NA        = (ADDR_WIDTH + 7) / 8;
    localparam logic [1:0] LAST_ADDR = 2'(NA - 1);

    state_t              state;
    logic [1:0]          cnt;
    logic [NA*8-1:0]     addr_buf;
    logic [NA*8+7:0]     addr_shift;
    logic                rx_fire;
    logic                ack;
    logic                sh_load;
    logic [31:0]         sh_data;
    logic [2:0]          sh_count;
    logic                sh_last;
    logic                unused_bits;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo;
    logic          tmo_hit;
    assign tmo_hit = (tmo == TW'(1));
`else
    logic [7:0] unused_tmo;
    assign unused_tmo = 8'(TIMEOUT_CYCLES);
`endif

    assign rx_fire = i_rx_valid && o_rx_ready;
    // Only a clean sampled 1 is an ack; an undriven bus must not count.
    assign ack     = (i_wb_ack === 1'b1);
    // Address bytes arrive LSB first: shift each new byte in at the top.
    assign addr_shift = {i_rx_data, addr_buf};
    assign o_addr  = addr_buf[ADDR_WIDTH-1:0];
    assign o_busy  = (state != ST_CMD);
    assign unused_bits = ^{i_rx_data[6:2], addr_buf};

    // Response loading is decoded combinationally so the first TX byte is
    // presented in the same cycle the FSM enters RESP.
    always_comb begin
        sh_load  = 1'b0;
        sh_data  = {24'h0, RESP_ERR};
        sh_count = 3'd1;
        case (state)
            ST_CMD: begin
                if (rx_fire && i_rx_data[1:0] == W_BAD) sh_load = 1'b1;
            end
            ST_REQ, ST_WAIT: begin
                if (ack) begin
                    sh_load  = 1'b1;
                    sh_data  = o_we ? {24'h0, RESP_OK} : i_data;
                    sh_count = o_we ? 3'd1 : width_bytes(o_width);
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (tmo_hit) begin
                    sh_load = 1'b1;
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_CMD;
            cnt        <= '0;
            addr_buf   <= '0;
            o_we       <= 1'b0;
            o_width    <= W8;
            o_data     <= '0;
            o_wb_cyc   <= 1'b0;
            o_wb_stb   <= 1'b0;
            o_rx_ready <= 1'b0;
        end else begin
            case (state)
                ST_CMD: begin
                    o_rx_ready <= 1'b1;
                    if (rx_fire) begin
                        o_we    <= i_rx_data[7];
                        o_width <= i_rx_data[1:0];
                        o_data  <= '0;
                        cnt     <= '0;
                        if (i_rx_data[1:0] == W_BAD) begin
                            state      <= ST_RESP;
                            o_rx_ready <= 1'b0;
                        end else begin
                            state <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) begin
                        addr_buf <= addr_shift[NA*8+7:8];
                        if (cnt == LAST_ADDR) begin
                            cnt <= '0;
                            if (o_we) begin
                                state <= ST_WDATA;
                            end else begin
                                state      <= ST_REQ;
                                o_rx_ready <= 1'b0;
                                o_wb_cyc   <= 1'b1;
                                o_wb_stb   <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_fire) begin
                        o_data[{cnt, 3'b000} +: 8] <= i_rx_data;
                        if ({1'b0, cnt} == width_bytes(o_width) - 3'd1) begin
                            cnt        <= '0;
                            state      <= ST_REQ;
                            o_rx_ready <= 1'b0;
                            o_wb_cyc   <= 1'b1;
                            o_wb_stb   <= 1'b1;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                ST_REQ: begin
                    if (sh_load) begin
                        state    <= ST_RESP;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                    end else if (!i_wb_stl) begin
                        state    <= ST_WAIT;
                        o_wb_stb <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (sh_load) begin
                        state    <= ST_RESP;
                        o_wb_cyc <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (sh_last && o_tx_valid && i_tx_ready) begin
                        state      <= ST_CMD;
                        o_rx_ready <= 1'b1;
                    end
                end
                default: state <= ST_CMD;
            endcase
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    // Down-counter armed outside the bus phase, counting through REQ and WAIT.
    always_ff @(posedge clk) begin
        if (reset || (state != ST_REQ && state != ST_WAIT)) begin
            tmo <= TW'(TIMEOUT_CYCLES);
        end else begin
            tmo <= tmo - TW'(1);
        end
    end
`endif

    wb_serial_master_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load       (sh_load),
        .load_data  (sh_data),
        .load_count (sh_count),
        .tx_valid   (o_tx_valid),
        .tx_data    (o_tx_data),
        .tx_ready   (i_tx_ready),
        .last       (sh_last)
    );

endmodule

// File: tb/tb_wb_serial_master.sv
module tb_wb_serial_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        o_rx_ready;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b1;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_stl;
    logic        i_wb_ack = 1'b0;
    logic        o_we;
    logic [1:0]  o_width;
    logic [5:0]  o_addr;
    logic [31:0] o_data;
    logic [31:0] i_data = 32'h0;
    logic        o_busy;

    always #5 clk = ~clk;

    wb_serial_master #(.ADDR_WIDTH(6), .TIMEOUT_CYCLES(255)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_rx_ready (o_rx_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .i_tx_ready (i_tx_ready),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .i_wb_stl   (i_wb_stl),
        .i_wb_ack   (i_wb_ack),
        .o_we       (o_we),
        .o_width    (o_width),
        .o_addr     (o_addr),
        .o_data     (o_data),
        .i_data     (i_data),
        .o_busy     (o_busy)
    );

    // Registered-ack memory slave with programmable stall and ack suppression.
    logic [7:0]  mem [0:63];
    int          stall_req = 0;
    int          stall_used = 0;
    int          acc_count = 0;
    int          stb_cycles = 0;
    logic        noack = 1'b0;
    logic [5:0]  last_addr = 6'h0;
    logic        last_we = 1'b0;
    logic [1:0]  last_width = 2'b0;
    logic [31:0] last_data = 32'h0;

    assign i_wb_stl = o_wb_stb && (stall_used < stall_req);

    always @(posedge clk) begin
        i_wb_ack <= 1'b0;
        if (!o_wb_stb) stall_used <= 0;
        if (o_wb_cyc && o_wb_stb) begin
            stb_cycles <= stb_cycles + 1;
            if (i_wb_stl) begin
                stall_used <= stall_used + 1;
            end else begin
                acc_count  <= acc_count + 1;
                last_addr  <= o_addr;
                last_we    <= o_we;
                last_width <= o_width;
                last_data  <= o_data;
                if (!noack) i_wb_ack <= 1'b1;
                if (o_we) begin
                    mem[o_addr] <= o_data[7:0];
                    if (o_width != 2'b00) mem[6'(o_addr + 6'd1)] <= o_data[15:8];
                    if (o_width == 2'b10) begin
                        mem[6'(o_addr + 6'd2)] <= o_data[23:16];
                        mem[6'(o_addr + 6'd3)] <= o_data[31:24];
                    end
                end else begin
                    i_data <= {mem[6'(o_addr + 6'd3)], mem[6'(o_addr + 6'd2)],
                               mem[6'(o_addr + 6'd1)], mem[o_addr]};
                end
            end
        end
    end

    int         total = 0;
    int         pass_cnt = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int k;
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        k = 0;
        while (!o_rx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("rx_accept", 32'(o_rx_ready), 32'd1);
        @(negedge clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic recv_all(input int bound);
        int         k;
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            k = 0;
            while (!o_tx_valid && k < bound) begin
                @(negedge clk);
                k++;
            end
            if (!o_tx_valid) begin
                check("tx_valid_timeout", 32'(o_tx_valid), 32'd1);
            end else begin
                check("tx_byte", 32'(o_tx_data), 32'(e));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int a0;
        int s0;
        int k;
        int vcnt;

        repeat (3) @(negedge clk);
        check("rst_cyc",      32'(o_wb_cyc),   32'd0);
        check("rst_stb",      32'(o_wb_stb),   32'd0);
        check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        check("rst_rx_ready", 32'(o_rx_ready), 32'd0);
        check("rst_busy",     32'(o_busy),     32'd0);
        check("rst_attr",     {23'd0, o_we, o_width, o_addr}, 32'd0);
        check("rst_data",     o_data, 32'd0);
        reset = 1'b0;

        // Byte write
        exp_q.push_back(8'hAA);
        send(8'h80); send(8'h05); send(8'h5A);
        recv_all(100);
        check("wb_addr",  32'(last_addr),  32'd5);
        check("wb_we",    32'(last_we),    32'd1);
        check("wb_width", 32'(last_width), 32'd0);
        check("wb_data",  last_data,       32'h0000005A);
        check("mem5",     32'(mem[5]),     32'h5A);
        check("acc1",     32'(acc_count),  32'd1);
        check("idle_busy", 32'(o_busy),    32'd0);

        // Word write
        exp_q.push_back(8'hAA);
        send(8'h82); send(8'h08); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        recv_all(100);
        check("ww_data",  last_data,       32'h12345678);
        check("ww_width", 32'(last_width), 32'd2);
        check("mem11",    32'(mem[11]),    32'h12);

        // Word read
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        send(8'h02); send(8'h08);
        recv_all(100);
        check("rw_we",    32'(last_we),    32'd0);
        check("rw_width", 32'(last_width), 32'd2);

        // Half-word read at an odd address
        exp_q.push_back(8'h56); exp_q.push_back(8'h34);
        send(8'h01); send(8'h09);
        recv_all(100);
        check("rh_addr", 32'(last_addr), 32'd9);

        // Address bits above the bus width are dropped
        exp_q.push_back(8'h5A);
        send(8'h00); send(8'hC5);
        recv_all(100);
        check("trunc_addr", 32'(last_addr), 32'd5);

        // Stall for three cycles
        stall_req = 3;
        a0 = acc_count;
        s0 = stb_cycles;
        exp_q.push_back(8'h5A);
        send(8'h00); send(8'h05);
        recv_all(100);
        check("stall_stb_cycles", 32'(stb_cycles - s0), 32'd4);
        check("stall_accesses",   32'(acc_count - a0),  32'd1);
        stall_req = 0;

        // TX back-pressure
        i_tx_ready = 1'b0;
        send(8'h02); send(8'h08);
        k = 0;
        while (!o_tx_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp_valid",    32'(o_tx_valid), 32'd1);
            check("bp_data",     32'(o_tx_data),  32'h78);
            check("bp_rx_ready", 32'(o_rx_ready), 32'd0);
            @(negedge clk);
        end
        exp_q.push_back(8'h78); exp_q.push_back(8'h56);
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        i_tx_ready = 1'b1;
        recv_all(100);

        // Invalid width, then a normal frame
        a0 = acc_count;
        s0 = stb_cycles;
        exp_q.push_back(8'hEE);
        send(8'h03);
        recv_all(100);
        check("bad_no_access", 32'(acc_count),  32'(a0));
        check("bad_no_stb",    32'(stb_cycles), 32'(s0));
        exp_q.push_back(8'h5A);
        send(8'h00); send(8'h05);
        recv_all(100);

        // Reset while waiting for an ack that never comes
        noack = 1'b1;
        send(8'h00); send(8'h05);
        k = 0;
        while (!(o_wb_cyc && !o_wb_stb) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("in_wait_cyc", 32'(o_wb_cyc), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_cyc",  32'(o_wb_cyc),   32'd0);
        check("mid_rst_busy", 32'(o_busy),     32'd0);
        check("mid_rst_addr", 32'(o_addr),     32'd0);
        reset = 1'b0;
        noack = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_tx_valid) vcnt++;
        end
        check("mid_rst_no_tx", 32'(vcnt), 32'd0);
        exp_q.push_back(8'h5A);
        send(8'h00); send(8'h05);
        recv_all(100);

`ifdef WB_MASTER_TIMEOUT_EN
        noack = 1'b1;
        exp_q.push_back(8'hEE);
        send(8'h00); send(8'h05);
        recv_all(400);
        check("tmo_cyc", 32'(o_wb_cyc), 32'd0);
        noack = 1'b0;
        exp_q.push_back(8'h5A);
        send(8'h00); send(8'h05);
        recv_all(100);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed %0d/%0d", pass_cnt, total);
        $fatal(1);
    end

endmodule
